// File: rtl/pwm_bank_if.sv
// pwm_bank_if: configuration handshake bus for pwm_bank
// Signals:
//   cfg_valid  - master offers a new configuration
//   cfg_ready  - slave can accept a configuration
//   cfg_period - PWM period in clk cycles
//   cfg_duty   - per-channel high time, channel i at [i*CNT_W +: CNT_W]
//   cfg_phase  - per-channel phase offset, packed like cfg_duty
//   cfg_dead   - dead time in cycles, shared by all channels
interface pwm_bank_if #(
  parameter int N_CH  = 2,
  parameter int CNT_W = 16,
  parameter int DT_W  = 8
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [CNT_W-1:0]      cfg_period;
  logic [N_CH*CNT_W-1:0] cfg_duty;
  logic [N_CH*CNT_W-1:0] cfg_phase;
  logic [DT_W-1:0]       cfg_dead;
  modport master (output cfg_valid, cfg_period, cfg_duty, cfg_phase, cfg_dead, input cfg_ready);
  modport slave  (input cfg_valid, cfg_period, cfg_duty, cfg_phase, cfg_dead, output cfg_ready);
endinterface

// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel phase-shifted PWM with complementary dead-time outputs
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-low reset
//   en      - run enable; counter held at 0 and gates forced low while 0
//   cfg     - pwm_bank_if slave; configurations are double-buffered and
//             applied only at a period boundary or while disabled
//   ctrl_hi - high-side gate drive per channel
//   ctrl_lo - low-side gate drive per channel
//   sync    - one-cycle pulse at the start of each period
module pwm_bank #(
  parameter int N_CH       = 2,
  parameter int CNT_W      = 16,
  parameter int DT_W       = 8,
  parameter int DEF_PERIOD = 100,
  parameter int DEF_DUTY   = 50,
  parameter int DEF_DEAD   = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  pwm_bank_if.slave       cfg,
  output logic [N_CH-1:0] ctrl_hi,
  output logic [N_CH-1:0] ctrl_lo,
  output logic            sync
);
  localparam int RW = DT_W + 1;
  logic [CNT_W-1:0]          a_period, p_period, cnt, per;
  logic [N_CH*CNT_W-1:0]     a_duty, a_phase, p_duty, p_phase;
  logic [DT_W-1:0]           a_dead, p_dead;
  logic                      p_valid, wrap, apply, accept;
  logic [N_CH-1:0]           raw, last_raw, hi_nxt, lo_nxt;
  logic [N_CH-1:0][RW-1:0]   run, run_nxt;
  assign per          = a_period < CNT_W'(2) ? CNT_W'(2) : a_period;
  assign wrap         = en && cnt == per - CNT_W'(1);
  assign apply        = p_valid && (wrap || !en);
  assign accept       = cfg.cfg_valid && !p_valid;
  assign cfg.cfg_ready = !p_valid;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] ph, duty;
    logic [CNT_W:0]   sum, pos;
    logic             same;
    assign duty = a_duty[i*CNT_W +: CNT_W];
    assign ph   = a_phase[i*CNT_W +: CNT_W] >= per ? '0 : a_phase[i*CNT_W +: CNT_W];
    assign sum  = {1'b0, cnt} + {1'b0, ph};
    assign pos  = sum >= {1'b0, per} ? sum - {1'b0, per} : sum;
    assign raw[i] = en && pos < {1'b0, duty};
    // run counts consecutive equal raw samples; 0 means no valid history
    // (after reset, while disabled, or after a dead-time change), so outputs
    // stay low until D+1 real samples agree
    assign same       = raw[i] == last_raw[i] && run[i] != '0;
    assign run_nxt[i] = !en ? '0 : !same ? RW'(1) : &run[i] ? run[i] : run[i] + RW'(1);
    assign hi_nxt[i]  = raw[i] && run_nxt[i] > {1'b0, a_dead};
    assign lo_nxt[i]  = en && !raw[i] && run_nxt[i] > {1'b0, a_dead};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      a_period <= CNT_W'(DEF_PERIOD);
      a_duty   <= {N_CH{CNT_W'(DEF_DUTY)}};
      a_phase  <= '0;
      a_dead   <= DT_W'(DEF_DEAD);
      p_period <= '0;
      p_duty   <= '0;
      p_phase  <= '0;
      p_dead   <= '0;
      p_valid  <= 1'b0;
      run      <= '0;
      last_raw <= '0;
      ctrl_hi  <= '0;
      ctrl_lo  <= '0;
      sync     <= 1'b0;
    end else begin
      cnt      <= !en || wrap ? '0 : cnt + CNT_W'(1);
      last_raw <= raw;
      run      <= apply && p_dead != a_dead ? '0 : run_nxt;
      ctrl_hi  <= hi_nxt;
      ctrl_lo  <= lo_nxt;
      sync     <= en && cnt == '0;
      // accept needs p_valid=0 and apply needs p_valid=1, so they never collide;
      // an accept in a wrap cycle therefore waits for the following wrap
      if (accept) begin
        p_period <= cfg.cfg_period;
        p_duty   <= cfg.cfg_duty;
        p_phase  <= cfg.cfg_phase;
        p_dead   <= cfg.cfg_dead;
        p_valid  <= 1'b1;
      end
      if (apply) begin
        a_period <= p_period;
        a_duty   <= p_duty;
        a_phase  <= p_phase;
        a_dead   <= p_dead;
        p_valid  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: directed self-checking bench for pwm_bank
module tb_pwm_bank;
  localparam int N_CH = 2, CNT_W = 16, DT_W = 8;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0;
  logic [N_CH-1:0] ctrl_hi, ctrl_lo;
  logic sync;
  int checks = 0, errors = 0;
  pwm_bank_if #(.N_CH(N_CH), .CNT_W(CNT_W), .DT_W(DT_W)) cfg();
  pwm_bank #(.N_CH(N_CH), .CNT_W(CNT_W), .DT_W(DT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg(cfg),
    .ctrl_hi(ctrl_hi), .ctrl_lo(ctrl_lo), .sync(sync)
  );
  always #5 clk = ~clk;
  task automatic drive_cfg(input logic [CNT_W-1:0] p, d0, d1, h0, h1, input logic [DT_W-1:0] dt);
    cfg.cfg_period = p;
    cfg.cfg_duty   = {d1, d0};
    cfg.cfg_phase  = {h1, h0};
    cfg.cfg_dead   = dt;
  endtask
  // disable, load a config while disabled, re-enable; the cycle en goes high has cnt=0
  task automatic restart(input logic [CNT_W-1:0] p, d0, d1, h0, h1, input logic [DT_W-1:0] dt);
    @(negedge clk) en = 1'b0;
    @(negedge clk) begin cfg.cfg_valid = 1'b1; drive_cfg(p, d0, d1, h0, h1, dt); end
    @(negedge clk) cfg.cfg_valid = 1'b0;
    @(negedge clk) en = 1'b1;
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if ({ctrl_hi, ctrl_lo, sync} !== 5'b0) begin errors++; $display("FAIL reset_outs got %b exp 00000", {ctrl_hi, ctrl_lo, sync}); end
    checks++; if (cfg.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", cfg.cfg_ready); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({ctrl_hi, ctrl_lo, sync} !== 5'b0) begin errors++; $display("FAIL idle_outs got %b exp 00000", {ctrl_hi, ctrl_lo, sync}); end
    checks++; if (cfg.cfg_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b exp 1", cfg.cfg_ready); end
  endtask
  task automatic test_basic;
    logic [1:0] eh;
    restart(10, 5, 5, 0, 0, 0);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      eh = {2{((n - 1) % 10) < 5}};
      checks++; if (ctrl_hi !== eh) begin errors++; $display("FAIL basic_hi n=%0d got %b exp %b", n, ctrl_hi, eh); end
      checks++; if (ctrl_lo !== ~eh) begin errors++; $display("FAIL basic_lo n=%0d got %b exp %b", n, ctrl_lo, ~eh); end
      checks++; if (sync !== ((n - 1) % 10 == 0)) begin errors++; $display("FAIL basic_sync n=%0d got %b exp %b", n, sync, (n - 1) % 10 == 0); end
    end
  endtask
  task automatic test_dead;
    logic [1:0] eh, el;
    int k;
    restart(10, 5, 5, 0, 0, 2);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      k = (n - 1) % 10;
      eh = {2{k >= 2 && k <= 4}};
      el = {2{k >= 7}};
      checks++; if (ctrl_hi !== eh) begin errors++; $display("FAIL dead_hi n=%0d got %b exp %b", n, ctrl_hi, eh); end
      checks++; if (ctrl_lo !== el) begin errors++; $display("FAIL dead_lo n=%0d got %b exp %b", n, ctrl_lo, el); end
      checks++; if ((ctrl_hi & ctrl_lo) !== 2'b00) begin errors++; $display("FAIL dead_overlap n=%0d got %b exp 00", n, ctrl_hi & ctrl_lo); end
    end
  endtask
  task automatic test_phase;
    logic [1:0] eh;
    restart(10, 5, 5, 0, 3, 0);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      eh = {((n + 2) % 10) < 5, ((n - 1) % 10) < 5};
      checks++; if (ctrl_hi !== eh) begin errors++; $display("FAIL phase3_hi n=%0d got %b exp %b", n, ctrl_hi, eh); end
    end
    restart(10, 5, 5, 0, 12, 0);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      eh = {2{((n - 1) % 10) < 5}};
      checks++; if (ctrl_hi !== eh) begin errors++; $display("FAIL phase12_hi n=%0d got %b exp %b", n, ctrl_hi, eh); end
    end
  endtask
  task automatic test_handshake;
    logic [1:0] eh;
    logic er;
    int d;
    restart(10, 5, 5, 0, 0, 0);
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      d = (n - 1) >= 10 ? 8 : 5;
      eh = {2{((n - 1) % 10) < d}};
      er = !(n >= 5 && n <= 9);
      checks++; if (ctrl_hi !== eh) begin errors++; $display("FAIL hs_hi n=%0d got %b exp %b", n, ctrl_hi, eh); end
      checks++; if (cfg.cfg_ready !== er) begin errors++; $display("FAIL hs_ready n=%0d got %b exp %b", n, cfg.cfg_ready, er); end
      if (n == 4) begin cfg.cfg_valid = 1'b1; drive_cfg(10, 8, 8, 0, 0, 0); end
      if (n == 6) begin cfg.cfg_valid = 1'b1; drive_cfg(10, 2, 2, 0, 0, 0); end
      if (n == 5 || n == 7) cfg.cfg_valid = 1'b0;
    end
  endtask
  task automatic test_limits;
    logic h;
    restart(10, 0, 15, 0, 0, 0);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      checks++; if (ctrl_hi !== 2'b10) begin errors++; $display("FAIL lim_hi n=%0d got %b exp 10", n, ctrl_hi); end
      checks++; if (ctrl_lo !== 2'b01) begin errors++; $display("FAIL lim_lo n=%0d got %b exp 01", n, ctrl_lo); end
    end
    restart(1, 1, 1, 0, 0, 0);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      h = ((n - 1) % 2) == 0;
      checks++; if (ctrl_hi !== {2{h}}) begin errors++; $display("FAIL p1_hi n=%0d got %b exp %b", n, ctrl_hi, {2{h}}); end
      checks++; if (sync !== h) begin errors++; $display("FAIL p1_sync n=%0d got %b exp %b", n, sync, h); end
    end
  endtask
  task automatic test_rst_mid;
    logic [1:0] eh;
    restart(10, 5, 5, 0, 0, 0);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 3) begin cfg.cfg_valid = 1'b1; drive_cfg(20, 2, 2, 0, 0, 0); end
      if (n == 4) cfg.cfg_valid = 1'b0;
    end
    @(negedge clk);
    checks++; if (ctrl_hi !== 2'b11) begin errors++; $display("FAIL pre_rst_hi got %b exp 11", ctrl_hi); end
    rst = 1'b0;
    #1;
    checks++; if ({ctrl_hi, ctrl_lo, sync} !== 5'b0) begin errors++; $display("FAIL rst_mid_outs got %b exp 00000", {ctrl_hi, ctrl_lo, sync}); end
    checks++; if (cfg.cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b exp 1", cfg.cfg_ready); end
    @(negedge clk) rst = 1'b1;
    for (int n = 1; n <= 110; n++) begin
      @(negedge clk);
      eh = {2{((n - 1) % 100) < 50}};
      checks++; if (ctrl_hi !== eh || ctrl_lo !== ~eh) begin errors++; $display("FAIL def_gates n=%0d got %b/%b exp %b/%b", n, ctrl_hi, ctrl_lo, eh, ~eh); end
      checks++; if (sync !== ((n - 1) % 100 == 0)) begin errors++; $display("FAIL def_sync n=%0d got %b exp %b", n, sync, (n - 1) % 100 == 0); end
    end
  endtask
  initial begin
    cfg.cfg_valid = 1'b0;
    drive_cfg(0, 0, 0, 0, 0, 0);
    test_reset;
    test_basic;
    test_dead;
    test_phase;
    test_handshake;
    test_limits;
    test_rst_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of PWM channels.
REQ-002 SHALL have parameter CNT_W, default 16: width of period, duty and phase fields.
REQ-003 SHALL have parameter DT_W, default 8: width of the dead-time field.
REQ-004 SHALL have parameters DEF_PERIOD (100), DEF_DUTY (50) and DEF_DEAD (0): the configuration loaded at reset.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port en, input, 1 bit: run enable.
REQ-008 SHALL have port cfg_valid, input, 1 bit: a new configuration is offered.
REQ-009 SHALL have port cfg_ready, output, 1 bit: the block can accept a configuration.
REQ-010 SHALL have port cfg_period, input, CNT_W bits: PWM period in clk cycles.
REQ-011 SHALL have port cfg_duty, input, N_CH*CNT_W bits: per-channel high time; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-012 SHALL have port cfg_phase, input, N_CH*CNT_W bits: per-channel phase offset, packed the same way.
REQ-013 SHALL have port cfg_dead, input, DT_W bits: dead time in cycles, shared by all channels.
REQ-014 SHALL have port ctrl_hi, output, N_CH bits: high-side gate drive.
REQ-015 SHALL have port ctrl_lo, output, N_CH bits: low-side gate drive, complementary to ctrl_hi.
REQ-016 SHALL have port sync, output, 1 bit: one-cycle pulse at the start of each period.

Function
REQ-017 SHALL keep three register sets: active configuration, pending configuration, and a pending-valid flag.
REQ-018 SHALL compute the effective period P = max(active period, 2).
REQ-019 SHALL clear the counter cnt to 0 while en=0; while en=1, cnt SHALL count 0..P-1 and then wrap to 0.
REQ-020 SHALL define the period boundary ("wrap") as a cycle with en=1 and cnt=P-1.
REQ-021 SHALL use phase ph_i = active phase_i, or 0 if phase_i >= P.
REQ-022 SHALL compute position pos_i = cnt+ph_i, minus P if that sum >= P, using CNT_W+1-bit arithmetic with no overflow.
REQ-023 SHALL set raw_i = 1 iff en=1 and pos_i < duty_i. Consequences: duty_i=0 gives raw_i always 0; duty_i >= P gives raw_i always 1 while enabled.
REQ-024 SHALL, for each channel, assert ctrl_hi[i] in cycle t iff raw_i=1 in all of cycles t-1-D .. t-1, where D is the active dead time.
REQ-025 SHALL, for each channel, assert ctrl_lo[i] in cycle t iff en=1 and raw_i=0 in all of cycles t-1-D .. t-1.
REQ-026 SHALL never have ctrl_hi[i] and ctrl_lo[i] both 1 in the same cycle.
REQ-027 SHALL implement the dead-time rule with a per-channel DT_W+1-bit saturating run counter; D=0 gives 1-cycle latency and exact complement.
REQ-028 SHALL drive both ctrl_hi and ctrl_lo to 0 in the cycle after en falls, and hold them at 0 while en=0.
REQ-029 SHALL assert sync in cycle t iff en=1 and cnt=0 in cycle t-1 (same 1-cycle latency as the gate outputs).
REQ-030 SHALL drive cfg_ready = NOT pending-valid.
REQ-031 SHALL accept a configuration when cfg_valid=1 and cfg_ready=1: all cfg_* fields are captured into pending and pending-valid is set.
REQ-032 SHALL ignore cfg_valid while cfg_ready=0.
REQ-033 SHALL copy pending into active and clear pending-valid on a wrap cycle; the new values take effect from cnt=0.
REQ-034 SHALL apply a pending configuration at the next clock edge when en=0.
REQ-035 SHALL apply an accept that occurs in a wrap cycle at the following wrap, not the current one.
REQ-036 SHALL never apply a configuration mid-period.
REQ-037 SHALL make cfg_ready 1 again in the cycle after an apply.
REQ-038 SHALL reset the dead-time run counters of all channels to 0 when a new active configuration changes D.

Reset
REQ-039 SHALL, while rst=0 and asynchronously, set cnt=0, active configuration = DEF_PERIOD/DEF_DUTY (all channels)/phase 0/DEF_DEAD, pending-valid=0, run counters 0, ctrl_hi=0, ctrl_lo=0 and sync=0.
REQ-040 SHALL hold cfg_ready=1 from reset.
REQ-041 SHALL keep outputs at 0 after reset release until the REQ-024/REQ-025 history is satisfied; no glitch output is permitted.
REQ-042 SHALL discard any pending configuration when rst is asserted mid-operation.

Verification
REQ-043 Bench SHALL check: N_CH=2, config P=10, duty 5/5, phase 0/0, D=0, en=1 -> ctrl_hi high 5 cycles, low 5 cycles; ctrl_lo exactly inverted; sync every 10 cycles, one cycle after cnt=0.
REQ-044 Bench SHALL check: the same config with D=2 -> ctrl_hi high 3 cycles; ctrl_lo high 3 cycles; two 2-cycle gaps per period with both outputs low; never both high.
REQ-045 Bench SHALL check: ch1 phase=3 with P=10, duty 5 -> ch1 ctrl_hi leads ch0 by 3 cycles; phase=12 behaves as phase 0.
REQ-046 Bench SHALL check: cfg_valid at cnt=4 with duty 8 -> cfg_ready drops; the old duty holds through cnt=9; the new duty applies from cnt=0; cfg_ready returns one cycle after that; a second offer while not ready is ignored.
REQ-047 Bench SHALL check: duty 0 -> ctrl_hi stays 0 and ctrl_lo stays 1; duty 15 with P=10 -> ctrl_hi stays 1; period 1 -> behaves as P=2.
REQ-048 Bench SHALL check: rst pulsed low mid-period with a config pending -> outputs 0 immediately; after release the default 100/50 config runs and the pending config is lost.
